// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and FETCH_DEPTH-entry fetch queue feeding decode over valid/ready.
// Define FETCH_PERF_EN to add perf_fetched/perf_stall counters.
module fetch_unit #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32,
  parameter int FETCH_DEPTH = 4,
  parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [A_WIDTH-1:0] imem_addr,
  input  logic [D_WIDTH-1:0] imem_rdata,
  input  logic               redir_valid,
  input  logic [A_WIDTH-1:0] redir_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_instr,
  output logic [A_WIDTH-1:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);
  localparam int PW = $clog2(FETCH_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(FETCH_DEPTH);
  logic [D_WIDTH-1:0] q_instr [FETCH_DEPTH];
  logic [A_WIDTH-1:0] q_pc [FETCH_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] occ;
  logic [A_WIDTH-1:0] fetch_pc, infl_addr;
  logic inflight, push, pop;
  // credit rule: queued plus in-flight never exceeds capacity, so responses always fit
  assign imem_req = !rst && !redir_valid && ((occ + {{PW{1'b0}}, inflight}) < FULL);
  assign imem_addr = fetch_pc;
  assign push = inflight && !redir_valid;
  assign pop = out_valid && out_ready;
  assign out_valid = occ != '0;
  assign out_instr = q_instr[rd_ptr];
  assign out_pc = q_pc[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      infl_addr <= '0;
      inflight <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc <= fetch_pc + A_WIDTH'(4);
        infl_addr <= fetch_pc;
      end
      if (redir_valid) begin
        fetch_pc <= redir_pc & ~A_WIDTH'(3);
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ <= '0;
      end else begin
        rd_ptr <= rd_ptr + PW'(pop);
        wr_ptr <= wr_ptr + PW'(push);
        occ <= occ + (PW+1)'(push) - (PW+1)'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr] <= infl_addr;
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_stall <= perf_stall + 32'(out_valid && !out_ready);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit latency, credit stall, redirect and reset.
module tb_fetch_unit;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 1'b0;
  logic rst, imem_req, redir_valid, out_valid, out_ready;
  logic [31:0] imem_addr, imem_rdata, redir_pc, out_instr, out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif
  int n_tests = 0;
  int n_fail = 0;
  int reqs;
  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (imem_req) imem_rdata <= imem_addr ^ K;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    if (out_valid) begin
      check({tag, "_pc"}, 64'(out_pc), 64'(pc));
      check({tag, "_instr"}, 64'(out_instr), 64'(pc ^ K));
    end
  endtask
  task automatic restart(input logic ready);
    cyc();
    rst = 1'b1;
    redir_valid = 1'b0;
    cyc();
    rst = 1'b0;
    out_ready = ready;
  endtask
  initial begin
    rst = 1'b1; out_ready = 1'b1; redir_valid = 1'b0; redir_pc = '0;
    cyc(); cyc();
    @(negedge clk);
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
`ifdef FETCH_PERF_EN
    check("rst_perf_fetched", 64'(perf_fetched), 64'd0);
    check("rst_perf_stall", 64'(perf_stall), 64'd0);
`endif
    // first fetch: C0 request, visible at C2, then one per cycle
    cyc(); rst = 1'b0;
    @(negedge clk);
    check("c0_req", 64'(imem_req), 64'd1);
    check("c0_addr", 64'(imem_addr), 64'h0);
    check("c0_valid", 64'(out_valid), 64'd0);
    cyc(); @(negedge clk);
    check("c1_valid", 64'(out_valid), 64'd0);
    check("c1_addr", 64'(imem_addr), 64'h4);
    cyc(); @(negedge clk);
    head("c2", 32'h0);
    for (int k = 1; k <= 5; k++) begin
      cyc(); @(negedge clk);
      head("stream", 32'(4 * k));
    end
    // stall: only FETCH_DEPTH requests, head held
    restart(1'b0);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      reqs += int'(imem_req);
      if (i >= 2) head("hold", 32'h0);
      cyc();
    end
    check("stall_reqs", 64'(reqs), 64'd4);
    @(negedge clk);
    check("stall_req_off", 64'(imem_req), 64'd0);
    cyc();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      head("drain", 32'(4 * k));
      cyc();
    end
    // redirect with 2 queued + 1 in flight (at C3)
    restart(1'b0);
    cyc(); cyc(); cyc();
    redir_valid = 1'b1; redir_pc = 32'h100;
    @(negedge clk);
    check("redir_noreq", 64'(imem_req), 64'd0);
    head("redir_old", 32'h0);
    cyc();
    redir_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("r1_req", 64'(imem_req), 64'd1);
    check("r1_addr", 64'(imem_addr), 64'h100);
    check("r1_valid", 64'(out_valid), 64'd0);
    cyc(); @(negedge clk);
    check("r2_valid", 64'(out_valid), 64'd0);
    cyc(); @(negedge clk);
    head("r3", 32'h100);
    cyc(); @(negedge clk);
    head("r4", 32'h104);
    // unaligned redirect coincident with handshake on 0x8 (C4)
    restart(1'b1);
    cyc(); cyc(); cyc(); cyc();
    redir_valid = 1'b1; redir_pc = 32'h103;
    @(negedge clk);
    head("hs_redir", 32'h8);
    cyc();
    redir_valid = 1'b0;
    @(negedge clk);
    check("ua_addr", 64'(imem_addr), 64'h100);
    check("ua_valid1", 64'(out_valid), 64'd0);
    cyc(); @(negedge clk);
    check("ua_valid2", 64'(out_valid), 64'd0);
    cyc(); @(negedge clk);
    head("ua_target", 32'h100);
    // reset pulse with 3 queued (C4)
    restart(1'b0);
    cyc(); cyc(); cyc(); cyc();
    @(negedge clk);
    head("pre_rst", 32'h0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("prst_valid", 64'(out_valid), 64'd0);
    check("prst_addr", 64'(imem_addr), 64'h0);
    check("prst_req", 64'(imem_req), 64'd1);
    cyc(); out_ready = 1'b1;
    @(negedge clk);
    check("prst_c1_valid", 64'(out_valid), 64'd0);
    cyc(); @(negedge clk);
    head("prst_c2", 32'h0);
`ifdef FETCH_PERF_EN
    restart(1'b1);
    @(negedge clk);
    check("perf_rst_fetched", 64'(perf_fetched), 64'd0);
    check("perf_rst_stall", 64'(perf_stall), 64'd0);
    repeat (12) cyc();
    out_ready = 1'b0;
    repeat (7) cyc();
    out_ready = 1'b1;
    repeat (10) cyc();
    out_ready = 1'b0;
    @(negedge clk);
    check("perf_fetched", 64'(perf_fetched), 64'd20);
    check("perf_stall", 64'(perf_stall), 64'd7);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
